// File: rtl/parity_frame_loader.sv
// Collects a 9-beat serial frame (8 data bits LSB first plus a parity bit) and launches a parity engine.
// It compares the engine result with the received parity bit. Optional watchdog: PARITY_FRAME_LOADER_TIMEOUT_EN.
module parity_frame_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic       rx_ready,
  output logic [7:0] data_out,
  output logic       start,
  input  logic       busy,
  input  logic       even_parity,
  input  logic       odd_parity,
  output logic       result_valid,
  output logic       frame_ok,
  output logic       protocol_err,
  output logic       timeout
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    COLLECT,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    REPORT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                p_q, p_d;
  logic                rx_ready_q, rx_ready_d;
  logic                start_q, start_d;
  logic                result_valid_q, result_valid_d;
  logic                frame_ok_q, frame_ok_d;
  logic                protocol_err_q, protocol_err_d;

`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
  localparam int unsigned WDOG_W = 6;
  localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};

  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                timeout_q, timeout_d;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    p_d            = p_q;
    frame_ok_d     = frame_ok_q;
    protocol_err_d = protocol_err_q;
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
    wdog_d         = wdog_q;
    timeout_d      = timeout_q;
`endif

    case (state_q)
      COLLECT: begin
        if (ser_valid) begin
          if (cnt_q == LAST_BEAT) begin
            p_d     = ser_in;
            cnt_d   = '0;
            state_d = LAUNCH;
          end else begin
            data_d[cnt_q[2:0]] = ser_in;
            cnt_d              = CNT_W'(cnt_q + 1'b1);
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      WAIT_BUSY: begin
        if (busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Engine flags are sampled on the cycle busy drops.
        if (!busy) begin
          state_d        = REPORT;
          protocol_err_d = (even_parity == odd_parity);
          frame_ok_d     = (odd_parity == p_q) && (even_parity != odd_parity);
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
          timeout_d      = 1'b0;
`endif
        end
      end
      REPORT: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase

`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
    // A completed handshake on the same cycle beats the watchdog.
    if ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) begin
      wdog_d = WDOG_W'(wdog_q + 1'b1);
      if ((state_d != REPORT) && (wdog_d == WDOG_MAX)) begin
        state_d        = REPORT;
        timeout_d      = 1'b1;
        frame_ok_d     = 1'b0;
        protocol_err_d = 1'b0;
      end
    end
`endif

    rx_ready_d     = (state_d == COLLECT);
    start_d        = (state_d == LAUNCH);
    result_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= COLLECT;
      cnt_q          <= '0;
      data_q         <= '0;
      p_q            <= 1'b0;
      rx_ready_q     <= 1'b1;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      frame_ok_q     <= 1'b0;
      protocol_err_q <= 1'b0;
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
      wdog_q         <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      p_q            <= p_d;
      rx_ready_q     <= rx_ready_d;
      start_q        <= start_d;
      result_valid_q <= result_valid_d;
      frame_ok_q     <= frame_ok_d;
      protocol_err_q <= protocol_err_d;
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
      wdog_q         <= wdog_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign data_out     = data_q;
  assign start        = start_q;
  assign result_valid = result_valid_q;
  assign frame_ok     = frame_ok_q;
  assign protocol_err = protocol_err_q;
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_loader.sv
// Directed bench for parity_frame_loader: serial frames, an engine model and a scoreboard of expected reports.
module tb_parity_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       ser_valid;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       start;
  logic       busy;
  logic       even_parity;
  logic       odd_parity;
  logic       result_valid;
  logic       frame_ok;
  logic       protocol_err;
  logic       timeout;

  parity_frame_loader dut (
    .clk          (clk),
    .rst          (rst),
    .ser_in       (ser_in),
    .ser_valid    (ser_valid),
    .rx_ready     (rx_ready),
    .data_out     (data_out),
    .start        (start),
    .busy         (busy),
    .even_parity  (even_parity),
    .odd_parity   (odd_parity),
    .result_valid (result_valid),
    .frame_ok     (frame_ok),
    .protocol_err (protocol_err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       fo;
    logic       pe;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_data"}, 32'(data_out), 32'd0);
    check({tag, "_fo"}, 32'(frame_ok), 32'd0);
    check({tag, "_pe"}, 32'(protocol_err), 32'd0);
    check({tag, "_to"}, 32'(timeout), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input bit gaps, output int ticks);
    logic [8:0] bits;
    bits  = {p, d};
    ticks = 0;
    for (int i = 0; i < 9; i++) begin
      ser_valid = 1'b1;
      ser_in    = bits[i];
      tick();
      ticks++;
      if (gaps && i < 8) begin
        ser_valid = 1'b0;
        ser_in    = 1'($urandom);
        tick();
        ticks++;
      end
    end
    ser_valid = 1'b0;
  endtask

  // Called in the LAUNCH cycle; returns after the REPORT cycle.
  task automatic engine(input int busy_cycles, input logic ev, input logic od, input logic [7:0] d);
    int lat;
    lat = 0;
    tick();
    lat++;
    check("start_one_cycle", 32'(start), 32'd0);
    busy      = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'($urandom);
    repeat (busy_cycles) begin
      tick();
      lat++;
      ser_in = ~ser_in;
    end
    busy        = 1'b0;
    even_parity = ev;
    odd_parity  = od;
    while (result_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    ser_valid = 1'b0;
    check("latency", 32'(lat), 32'(busy_cycles + 2));
    check("data_hold", 32'(data_out), 32'(d));
    tick();
    check("rv_one_cycle", 32'(result_valid), 32'd0);
    check("rx_ready_back", 32'(rx_ready), 32'd1);
  endtask

  task automatic do_frame(input logic [7:0] d, input logic p, input bit gaps,
                          input int busy_cycles, input logic ev, input logic od);
    exp_t e;
    int   ticks;
    e.data = d;
    e.pe   = (ev == od);
    e.fo   = (od == p) && !e.pe;
    e.to   = 1'b0;
    sb_q.push_back(e);
    send_frame(d, p, gaps, ticks);
    check("launch_ticks", 32'(ticks), gaps ? 32'd17 : 32'd9);
    check("launch_start", 32'(start), 32'd1);
    check("launch_rx_ready", 32'(rx_ready), 32'd0);
    check("launch_data", 32'(data_out), 32'(d));
    engine(busy_cycles, ev, od, d);
  endtask

  // Scoreboard: every result_valid pulse must match the oldest expected report.
  always @(negedge clk) begin
    if (rst === 1'b0 && result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rv", 32'(result_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_data", 32'(data_out), 32'(mon_e.data));
        check("sb_frame_ok", 32'(frame_ok), 32'(mon_e.fo));
        check("sb_protocol_err", 32'(protocol_err), 32'(mon_e.pe));
        check("sb_timeout", 32'(timeout), 32'(mon_e.to));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int   ticks;
    int   lat;
    exp_t e;

    rst         = 1'b1;
    ser_in      = 1'b0;
    ser_valid   = 1'b0;
    busy        = 1'b0;
    even_parity = 1'b0;
    odd_parity  = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    do_frame(8'h91, 1'b1, 1'b0, 20, 1'b0, 1'b1);
    do_frame(8'hFF, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    do_frame(8'h00, 1'b0, 1'b1, 4, 1'b1, 1'b0);
    do_frame(8'h3C, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    do_frame(8'h07, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    check("result_held", 32'(protocol_err), 32'd1);

    // Reset while the engine is busy: frame dropped, no report.
    send_frame(8'h5A, 1'b0, 1'b0, ticks);
    tick();
    busy = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_idle("rst_wait_done");
    tick();
    busy = 1'b0;
    rst  = 1'b0;
    repeat (10) tick();
    check("post_rst_start", 32'(start), 32'd0);

    // Reset mid-frame must restart the beat counter.
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'b1;
      tick();
    end
    ser_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    do_frame(8'hA5, 1'b0, 1'b0, 5, 1'b1, 1'b0);

    // Engine never raises busy.
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
    e.data = 8'hC3;
    e.fo   = 1'b0;
    e.pe   = 1'b0;
    e.to   = 1'b1;
    sb_q.push_back(e);
`endif
    send_frame(8'hC3, 1'b0, 1'b0, ticks);
    check("hang_start", 32'(start), 32'd1);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
`ifdef PARITY_FRAME_LOADER_TIMEOUT_EN
    check("timeout_latency", 32'(lat), 32'd64);
    tick();
    check("timeout_held", 32'(timeout), 32'd1);
    check("timeout_rx_ready", 32'(rx_ready), 32'd1);
`else
    check("hang_no_rv", 32'(lat), 32'd100);
    check("hang_timeout_zero", 32'(timeout), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("hang_recovered", 32'(rx_ready), 32'd1);
`endif

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
